// File: rtl/inst_loader.sv
// Instruction image loader: collects a little-endian byte stream into
// words, writes them to instruction memory, and keeps the core in reset
// until a complete image has been loaded.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start after reset; core held in reset
// RECV  | accepting bytes into the assembly register (byte_ready=1)
// WRITE | one-cycle memory write of the assembled word
// DONE  | image complete; core released from reset
// ERROR | image ended mid-word or overflowed memory; core held in reset
module inst_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     byte_last,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]         mem_wd,
    output logic                     cpu_reset,
    output logic                     done,
    output logic                     error,
    output logic [$clog2(DEPTH):0]   words_loaded
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   ONE_WORD = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [1:0]      r_lane;
    logic [AW-1:0]   r_word_idx;
    logic [AW:0]     r_words_loaded;
    logic [31:0]     r_asm;
    logic            r_word_last;

    logic            w_accept;
    logic            w_lane_full;
    logic            w_last_slot;

    assign w_accept    = byte_valid && (r_state == RECV);
    assign w_lane_full = (r_lane == 2'd3);
    assign w_last_slot = (r_word_idx == LAST_IDX);

    // State register; reset returns to IDLE from anywhere, including WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RECV;
                end
            end
            RECV: begin
                if (w_accept) begin
                    if (w_lane_full) begin
                        w_next_state = WRITE;
                    end else if (byte_last) begin
                        // image ended inside a word: the partial word is dropped
                        w_next_state = ERROR;
                    end
                end
            end
            WRITE: begin
                if (r_word_last) begin
                    w_next_state = DONE;
                end else if (w_last_slot) begin
                    w_next_state = ERROR;
                end else begin
                    w_next_state = RECV;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    w_next_state = RECV;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Byte assembly, word index and session word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane         <= 2'd0;
            r_word_idx     <= '0;
            r_words_loaded <= '0;
            r_asm          <= 32'd0;
            r_word_last    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_lane         <= 2'd0;
                        r_word_idx     <= '0;
                        r_words_loaded <= '0;
                        r_word_last    <= 1'b0;
                    end
                end
                RECV: begin
                    if (w_accept) begin
                        r_asm[{r_lane, 3'b000} +: 8] <= byte_in;
                        r_lane                       <= r_lane + 2'd1;
                        if (w_lane_full) begin
                            r_word_last <= byte_last;
                        end
                    end
                end
                WRITE: begin
                    r_words_loaded <= r_words_loaded + ONE_WORD;
                    // index only advances when another word will follow
                    if (!r_word_last && !w_last_slot) begin
                        r_word_idx <= r_word_idx + 1'b1;
                    end
                end
                default: begin
                    r_lane <= 2'd0;
                end
            endcase
        end
    end

    // Outputs decode straight from the state; the core runs only in DONE.
    always_comb begin
        byte_ready = (r_state == RECV);
        mem_we     = (r_state == WRITE);
        cpu_reset  = (r_state != DONE);
        done       = (r_state == DONE);
        error      = (r_state == ERROR);
    end

    assign mem_addr     = WIDTH'({r_word_idx, 2'b00});
    assign mem_wd       = WIDTH'(r_asm);
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected memory writes are queued as
// each image is driven and popped by a monitor whenever mem_we is seen.
module tb_inst_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int WLW   = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_last;
    logic             byte_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wd;
    logic             cpu_reset;
    logic             done;
    logic             error;
    logic [WLW-1:0]   words_loaded;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    inst_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
        sb_q.push_back({addr, data});
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_we", {mem_addr, mem_wd}, 64'd0);
            end else begin
                check("mem_write", {mem_addr, mem_wd}, sb_q.pop_front());
            end
        end
    end

    // All tasks below are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic lst, input int gap);
        int t;
        repeat (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in    = b;
        byte_last  = lst;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic pulse_start(input bit do_chk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (do_chk) begin
            check("start_cpu_reset", 64'(cpu_reset), 64'd1);
            check("start_done", 64'(done), 64'd0);
            check("start_error", 64'(error), 64'd0);
            check("start_ready", 64'(byte_ready), 64'd1);
            check("start_words", 64'(words_loaded), 64'd0);
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("end_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_we"}, 64'(mem_we), 64'd0);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(byte_ready), 64'd0);

        // single-word image
        push_write(32'h0, 32'h0000_0513);
        pulse_start(1'b1);
        send_byte(8'h13, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b1, 0);
        wait_end();
        check("t1_done", 64'(done), 64'd1);
        check("t1_error", 64'(error), 64'd0);
        check("t1_cpu_reset", 64'(cpu_reset), 64'd0);
        check("t1_words", 64'(words_loaded), 64'd1);
        check("t1_sb_empty", 64'(sb_q.size()), 64'd0);

        // restart from DONE, two words with stalls and a stray start mid-word
        pulse_start(1'b1);
        push_write(32'h0, 32'h0403_0201);
        push_write(32'h4, 32'h0807_0605);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), (i == 8), 1);
            if (i == 2) pulse_start(1'b0);
        end
        wait_end();
        check("t2_done", 64'(done), 64'd1);
        check("t2_words", 64'(words_loaded), 64'd2);
        check("t2_sb_empty", 64'(sb_q.size()), 64'd0);

        // image ends mid-word
        pulse_start(1'b1);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b1, 0);
        wait_end();
        check("t3_error", 64'(error), 64'd1);
        check("t3_done", 64'(done), 64'd0);
        check("t3_cpu_reset", 64'(cpu_reset), 64'd1);
        check("t3_words", 64'(words_loaded), 64'd0);
        check("t3_sb_empty", 64'(sb_q.size()), 64'd0);

        // overflow: DEPTH words fill memory, next byte must be refused
        pulse_start(1'b1);
        for (int w = 0; w < DEPTH; w++) begin
            push_write(32'(w * 4), {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
        end
        for (int i = 1; i <= 4 * DEPTH; i++) begin
            send_byte(8'(i), 1'b0, 0);
        end
        b          = 8'(4 * DEPTH + 1);
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_no_accept", 64'(byte_ready), 64'd0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("t4_error", 64'(error), 64'd1);
        check("t4_words", 64'(words_loaded), 64'(DEPTH));
        check("t4_sb_empty", 64'(sb_q.size()), 64'd0);

        // reset in the middle of the second word, then reload
        pulse_start(1'b1);
        push_write(32'h0, 32'h1413_1211);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h13, 1'b0, 0);
        send_byte(8'h14, 1'b0, 0);
        send_byte(8'h21, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_rst");
        reset = 1'b0;
        @(negedge clk);
        pulse_start(1'b1);
        push_write(32'h0, 32'h3433_3231);
        send_byte(8'h31, 1'b0, 0);
        send_byte(8'h32, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h34, 1'b1, 0);
        wait_end();
        check("t5_done", 64'(done), 64'd1);
        check("t5_words", 64'(words_loaded), 64'd1);
        check("t5_sb_empty", 64'(sb_q.size()), 64'd0);

        // reset landing on the WRITE cycle: write may happen, count must not
        pulse_start(1'b1);
        push_write(32'h0, 32'h4443_4241);
        send_byte(8'h41, 1'b0, 0);
        send_byte(8'h42, 1'b0, 0);
        send_byte(8'h43, 1'b0, 0);
        send_byte(8'h44, 1'b0, 0);
        check("t6_in_write", 64'(mem_we), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        @(negedge clk);
        check("t6_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
